countdown_timer_bank: RTL and testbench

Multi-channel, parametrised countdown timer for game and round timing. A shared internal prescaler derives the tick from the system clock. Each of `NUM_TIMERS` independent channels supports load/start, pause, resume and stop commands, plus one-shot or auto-reload mode. Each channel reports a one-cycle expiry pulse and a sticky expired flag. It sits between the control FSM, which issues commands, and the display/scoring logic, which reads the time values and flags.

---
 rtl/timer_pkg.sv | 16 +
 rtl/tick_prescaler.sv | 29 ++
 rtl/countdown_timer_bank.sv | 116 +++++++++++
 tb/tb_countdown_timer_bank.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared command encodings and channel state type for the countdown timer bank.
package timer_pkg;

  localparam logic [1:0] OP_LOAD_START = 2'd0;
  localparam logic [1:0] OP_PAUSE      = 2'd1;
  localparam logic [1:0] OP_RESUME     = 2'd2;
  localparam logic [1:0] OP_STOP       = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } ch_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: tick is high for one cycle out of every PRESCALE.
// tick decodes the terminal count directly; no backpressure, never stalls.
module tick_prescaler #(
  parameter int PRESCALE = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Gated by reset so a PRESCALE of 1 still reads 0 while held in reset.
  assign tick = reset && (cnt_q == LAST);

endmodule

// File: rtl/countdown_timer_bank.sv
// Bank of NUM_TIMERS countdown channels sharing one prescaled tick; outputs update on
// the edge that consumes a command or tick. Commands are always accepted (no backpressure).
module countdown_timer_bank
  import timer_pkg::*;
#(
  parameter int NUM_TIMERS = 2,
  parameter int TIMER_BITS = 6,
  parameter int MAX_TIME   = 30,
  parameter int PRESCALE   = 100_000_000,
  parameter int CH_BITS    = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cmd_valid,
  input  logic [CH_BITS-1:0]               cmd_ch,
  input  logic [1:0]                       cmd_op,
  input  logic [TIMER_BITS-1:0]            cmd_value,
  input  logic                             cmd_auto,
  output logic                             tick,
  output logic [NUM_TIMERS-1:0]            running,
  output logic [NUM_TIMERS-1:0]            expired_pulse,
  output logic [NUM_TIMERS-1:0]            expired,
  output logic [NUM_TIMERS*TIMER_BITS-1:0] time_flat
);

  localparam logic [TIMER_BITS-1:0] MAX_V = TIMER_BITS'(MAX_TIME);
  localparam logic [TIMER_BITS-1:0] ONE_V = TIMER_BITS'(1);

  logic [TIMER_BITS-1:0] load_val;

  assign load_val = (cmd_value == '0) ? MAX_V : cmd_value;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
    ch_state_t             st_q, st_d;
    logic [TIMER_BITS-1:0] val_q, val_d;
    logic [TIMER_BITS-1:0] rel_q, rel_d;
    logic                  auto_q, auto_d;
    logic                  exp_q, exp_d;
    logic                  pls_q, pls_d;
    logic                  hit;

    // Out-of-range channel indices never match any channel.
    assign hit = cmd_valid && (cmd_ch == CH_BITS'(i));

    always_comb begin
      st_d   = st_q;
      val_d  = val_q;
      rel_d  = rel_q;
      auto_d = auto_q;
      exp_d  = exp_q;
      pls_d  = 1'b0;
      // A command on this channel takes priority over a coincident tick.
      if (hit) begin
        case (cmd_op)
          OP_LOAD_START: begin
            val_d  = load_val;
            rel_d  = load_val;
            auto_d = cmd_auto;
            st_d   = ST_RUN;
            exp_d  = 1'b0;
          end
          OP_PAUSE:  if (st_q == ST_RUN)    st_d = ST_PAUSED;
          OP_RESUME: if (st_q == ST_PAUSED) st_d = ST_RUN;
          default: begin
            st_d  = ST_IDLE;
            val_d = MAX_V;
            exp_d = 1'b0;
          end
        endcase
      end else if (tick && st_q == ST_RUN) begin
        if (val_q > ONE_V) begin
          val_d = val_q - ONE_V;
        end else if (val_q == ONE_V) begin
          pls_d = 1'b1;
          exp_d = 1'b1;
          if (auto_q) begin
            val_d = rel_q;
          end else begin
            val_d = '0;
            st_d  = ST_DONE;
          end
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        st_q   <= ST_IDLE;
        val_q  <= MAX_V;
        rel_q  <= MAX_V;
        auto_q <= 1'b0;
        exp_q  <= 1'b0;
        pls_q  <= 1'b0;
      end else begin
        st_q   <= st_d;
        val_q  <= val_d;
        rel_q  <= rel_d;
        auto_q <= auto_d;
        exp_q  <= exp_d;
        pls_q  <= pls_d;
      end
    end

    assign running[i]       = (st_q == ST_RUN);
    assign expired[i]       = exp_q;
    assign expired_pulse[i] = pls_q;
    assign time_flat[i*TIMER_BITS +: TIMER_BITS] = val_q;
  end

endmodule

// File: tb/tb_countdown_timer_bank.sv
// Directed bench for countdown_timer_bank with NUM_TIMERS=2, TIMER_BITS=6, MAX_TIME=30, PRESCALE=4.
module tb_countdown_timer_bank;

  localparam int OPL = 0, OPP = 1, OPR = 2, OPS = 3;

  typedef struct {
    int vld, ch, op, val, au, n;
    int tk, run, pls, ex, t0, t1;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_ch = '0;
  logic [1:0]  cmd_op = '0;
  logic [5:0]  cmd_value = '0;
  logic        cmd_auto = 1'b0;
  logic        tick;
  logic [1:0]  running, expired_pulse, expired;
  logic [11:0] time_flat;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  countdown_timer_bank #(
    .NUM_TIMERS (2),
    .TIMER_BITS (6),
    .MAX_TIME   (30),
    .PRESCALE   (4),
    .CH_BITS    (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ch        (cmd_ch),
    .cmd_op        (cmd_op),
    .cmd_value     (cmd_value),
    .cmd_auto      (cmd_auto),
    .tick          (tick),
    .running       (running),
    .expired_pulse (expired_pulse),
    .expired       (expired),
    .time_flat     (time_flat)
  );

  function automatic vec_t mk(input int vld, ch, op, val, au, n, tk, run, pls, ex, t0, t1);
    mk = '{vld, ch, op, val, au, n, tk, run, pls, ex, t0, t1};
  endfunction

  task automatic chk(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  task automatic check_all(input string tag, input int tk, run, pls, ex, t0, t1);
    chk({tag, ".tick"}, int'(tick), tk);
    chk({tag, ".running"}, int'(running), run);
    chk({tag, ".expired_pulse"}, int'(expired_pulse), pls);
    chk({tag, ".expired"}, int'(expired), ex);
    chk({tag, ".time0"}, int'(time_flat[5:0]), t0);
    chk({tag, ".time1"}, int'(time_flat[11:6]), t1);
  endtask

  // Present one command (or idle) for one cycle; returns at the following negedge.
  task automatic step(input int vld, ch, op, val, au);
    cmd_valid = 1'(vld);
    cmd_ch    = 2'(ch);
    cmd_op    = 2'(op);
    cmd_value = 6'(val);
    cmd_auto  = 1'(au);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Rows: command for one cycle, then n-1 idle cycles, then compare.
    vecs.push_back(mk(1, 0, OPL, 3, 0, 1,   0, 1, 0, 0,  3, 30));
    vecs.push_back(mk(0, 0, 0,   0, 0, 3,   0, 1, 0, 0,  2, 30));
    vecs.push_back(mk(0, 0, 0,   0, 0, 4,   0, 1, 0, 0,  1, 30));
    vecs.push_back(mk(0, 0, 0,   0, 0, 3,   1, 1, 0, 0,  1, 30));
    vecs.push_back(mk(0, 0, 0,   0, 0, 1,   0, 0, 1, 1,  0, 30));
    vecs.push_back(mk(0, 0, 0,   0, 0, 1,   0, 0, 0, 1,  0, 30));
    vecs.push_back(mk(0, 0, 0,   0, 0, 8,   0, 0, 0, 1,  0, 30));
    vecs.push_back(mk(1, 1, OPL, 2, 1, 1,   0, 2, 0, 1,  0,  2));
    vecs.push_back(mk(0, 0, 0,   0, 0, 2,   0, 2, 0, 1,  0,  1));
    vecs.push_back(mk(0, 0, 0,   0, 0, 4,   0, 2, 2, 3,  0,  2));
    vecs.push_back(mk(0, 0, 0,   0, 0, 1,   0, 2, 0, 3,  0,  2));
    vecs.push_back(mk(0, 0, 0,   0, 0, 3,   0, 2, 0, 3,  0,  1));
    vecs.push_back(mk(0, 0, 0,   0, 0, 4,   0, 2, 2, 3,  0,  2));
    vecs.push_back(mk(1, 1, OPS, 0, 0, 1,   0, 0, 0, 1,  0, 30));
    vecs.push_back(mk(1, 0, OPL, 0, 0, 1,   0, 1, 0, 0, 30, 30));
    vecs.push_back(mk(0, 0, 0,   0, 0, 6,   0, 1, 0, 0, 28, 30));
    vecs.push_back(mk(1, 0, OPP, 0, 0, 1,   0, 0, 0, 0, 28, 30));
    vecs.push_back(mk(0, 0, 0,   0, 0, 12,  0, 0, 0, 0, 28, 30));
    vecs.push_back(mk(1, 0, OPR, 0, 0, 1,   0, 1, 0, 0, 28, 30));
    vecs.push_back(mk(0, 0, 0,   0, 0, 2,   0, 1, 0, 0, 27, 30));
    vecs.push_back(mk(1, 0, OPR, 0, 0, 1,   0, 1, 0, 0, 27, 30));
    vecs.push_back(mk(1, 1, OPP, 0, 0, 1,   0, 1, 0, 0, 27, 30));
    vecs.push_back(mk(1, 2, OPS, 0, 0, 1,   1, 1, 0, 0, 27, 30));
    vecs.push_back(mk(1, 2, OPL, 5, 0, 1,   0, 1, 0, 0, 26, 30));
    vecs.push_back(mk(1, 0, OPL, 2, 0, 1,   0, 1, 0, 0,  2, 30));
    vecs.push_back(mk(0, 0, 0,   0, 0, 3,   0, 1, 0, 0,  1, 30));
    vecs.push_back(mk(0, 0, 0,   0, 0, 3,   1, 1, 0, 0,  1, 30));
    vecs.push_back(mk(1, 0, OPP, 0, 0, 1,   0, 0, 0, 0,  1, 30));
    vecs.push_back(mk(0, 0, 0,   0, 0, 4,   0, 0, 0, 0,  1, 30));
    vecs.push_back(mk(1, 0, OPR, 0, 0, 1,   0, 1, 0, 0,  1, 30));
    vecs.push_back(mk(0, 0, 0,   0, 0, 2,   1, 1, 0, 0,  1, 30));
    vecs.push_back(mk(1, 1, OPL, 5, 0, 1,   0, 2, 1, 1,  0,  5));
    vecs.push_back(mk(0, 0, 0,   0, 0, 4,   0, 2, 0, 1,  0,  4));
    vecs.push_back(mk(0, 0, 0,   0, 0, 15,  1, 2, 0, 1,  0,  1));
    vecs.push_back(mk(1, 1, OPS, 0, 0, 1,   0, 0, 0, 1,  0, 30));

    repeat (3) @(negedge clk);
    reset = 1'b1;
    check_all("reset", 0, 0, 0, 0, 30, 30);

    for (int k = 1; k <= 12; k++) begin
      step(0, 0, 0, 0, 0);
      check_all($sformatf("idle%0d", k), (k % 4 == 3) ? 1 : 0, 0, 0, 0, 30, 30);
    end

    foreach (vecs[k]) begin
      step(vecs[k].vld, vecs[k].ch, vecs[k].op, vecs[k].val, vecs[k].au);
      for (int w = 1; w < vecs[k].n; w++) step(0, 0, 0, 0, 0);
      check_all($sformatf("row%0d", k), vecs[k].tk, vecs[k].run, vecs[k].pls,
                vecs[k].ex, vecs[k].t0, vecs[k].t1);
    end

    // Reset mid-count with ch0 running and ch1 paused, off the prescaler's zero phase.
    step(1, 0, OPL, 14, 0);
    step(1, 1, OPL, 9, 0);
    step(1, 1, OPP, 0, 0);
    for (int w = 0; w < 6; w++) step(0, 0, 0, 0, 0);
    check_all("pre_reset", 0, 1, 0, 0, 12, 9);
    reset = 1'b0;
    @(negedge clk);
    check_all("in_reset", 0, 0, 0, 0, 30, 30);
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 0, 0, 0);
      chk($sformatf("post_reset_tick%0d", k), int'(tick), (k % 4 == 3) ? 1 : 0);
    end
    chk("post_reset_time0", int'(time_flat[5:0]), 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
